lsu_req: RTL and testbench



---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_load_align.sv | 33 +++
 rtl/lsu_req.sv | 132 +++++++++++++
 tb/tb_lsu_req.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, FSM state type and width helpers for the LSU.
//   W8/W16/W32/W64 : one-hot access-width encodings
//   lsu_state_e    : request FSM states
//   wdt_norm       : maps any non-one-hot width onto W64
//   wdt_base       : width -> unshifted byte-strobe pattern
//   wdt_misalign   : width + byte offset -> natural-alignment violation
package lsu_pkg;

  localparam logic [3:0] W8  = 4'b0001;
  localparam logic [3:0] W16 = 4'b0010;
  localparam logic [3:0] W32 = 4'b0100;
  localparam logic [3:0] W64 = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] wdt_norm(input logic [3:0] w);
    case (w)
      W8, W16, W32, W64: return w;
      default:           return W64;
    endcase
  endfunction

  function automatic logic [7:0] wdt_base(input logic [3:0] w);
    case (w)
      W8:      return 8'h01;
      W16:     return 8'h03;
      W32:     return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic wdt_misalign(input logic [3:0] w, input logic [2:0] off);
    case (w)
      W8:      return 1'b0;
      W16:     return off[0];
      W32:     return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data extractor.
//   i_rdata : raw aligned doubleword from memory
//   i_off   : byte offset of the access inside the doubleword
//   i_wdt   : one-hot access width (already normalised)
//   i_sext  : replicate the width's top bit instead of zero-filling
//   o_data  : extended result
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_off,
  input  logic [3:0]      i_wdt,
  input  logic            i_sext,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_sh;

  assign w_sh = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = w_sh;
    case (i_wdt)
      W8:      o_data = {{(XLEN-8){i_sext & w_sh[7]}},   w_sh[7:0]};
      W16:     o_data = {{(XLEN-16){i_sext & w_sh[15]}}, w_sh[15:0]};
      W32:     o_data = {{(XLEN-32){i_sext & w_sh[31]}}, w_sh[31:0]};
      default: o_data = w_sh;
    endcase
  end

endmodule

// File: rtl/lsu_req.sv
// lsu_req: load/store initiator on the doubleword data-memory port.
//   in_*       : one request per transaction from execute (valid/ready)
//   mem_req_*  : aligned request with byte strobes (valid/ready)
//   mem_resp_* : read data / write ack from memory (valid/ready)
//   out_*      : extended load data and misalign flag to write-back
// One transaction in flight: IDLE -> REQ -> WAIT -> RESP -> IDLE, with
// misaligned and no-op requests short-circuiting IDLE -> RESP.
// All mem_* and out_* values come from registers or the state decode.
module lsu_req
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_wen,
  input  logic            in_ren,
  input  logic [3:0]      in_wdt,
  input  logic            in_sext,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_resp_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_misalign
);

  lsu_state_e      r_state, w_nxt;

  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [7:0]      r_wmask;
  logic            r_wen, r_ld, r_sext, r_mis;
  logic [2:0]      r_off;
  logic [3:0]      r_wdt;

  logic [3:0]      w_wdt;
  logic [2:0]      w_off;
  logic            w_mis, w_nop, w_acc, w_take;
  logic [XLEN-1:0] w_ld;

  assign w_wdt  = wdt_norm(in_wdt);
  assign w_off  = in_addr[2:0];
  assign w_mis  = wdt_misalign(w_wdt, w_off);
  assign w_nop  = ~in_wen & ~in_ren;
  assign w_acc  = (r_state == S_IDLE) & in_valid;
  assign w_take = (r_state == S_WAIT) & mem_resp_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next state
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid)       w_nxt = (w_mis | w_nop) ? S_RESP : S_REQ;
      S_REQ:  if (mem_req_ready)  w_nxt = S_WAIT;
      S_WAIT: if (mem_resp_valid) w_nxt = S_RESP;
      S_RESP: if (out_ready)      w_nxt = S_IDLE;
      default:                    w_nxt = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs
  always_comb begin
    in_ready       = (r_state == S_IDLE);
    mem_req_valid  = (r_state == S_REQ);
    mem_resp_ready = (r_state == S_WAIT);
    out_valid      = (r_state == S_RESP);
  end

  // Request/result datapath. Everything is captured at accept so the
  // request is stable through REQ; the result is cleared at accept so
  // stores, no-ops and misaligned accesses all report zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_wen   <= 1'b0;
      r_ld    <= 1'b0;
      r_sext  <= 1'b0;
      r_off   <= '0;
      r_wdt   <= W64;
      r_rdata <= '0;
      r_mis   <= 1'b0;
    end else if (w_acc) begin
      r_addr  <= {in_addr[XLEN-1:3], 3'b000};
      r_wdata <= in_wdata << {w_off, 3'b000};
      r_wmask <= in_wen ? (wdt_base(w_wdt) << w_off) : 8'h00;
      r_wen   <= in_wen & ~w_mis;
      // Store wins when both enables are set.
      r_ld    <= in_ren & ~in_wen;
      r_sext  <= in_sext;
      r_off   <= w_off;
      r_wdt   <= w_wdt;
      r_rdata <= '0;
      r_mis   <= w_mis;
    end else if (w_take) begin
      r_rdata <= r_ld ? w_ld : '0;
    end
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .i_rdata (mem_rdata),
    .i_off   (r_off),
    .i_wdt   (r_wdt),
    .i_sext  (r_sext),
    .o_data  (w_ld)
  );

  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign mem_wmask    = r_wmask;
  assign mem_wen      = r_wen;
  assign out_rdata    = r_rdata;
  assign out_misalign = r_mis;

endmodule

// File: tb/tb_lsu_req.sv
module tb_lsu_req;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_addr = '0, in_wdata = '0;
  logic        in_wen = 1'b0, in_ren = 1'b0, in_sext = 1'b0;
  logic [3:0]  in_wdt = W8;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0, mem_resp_ready;
  logic        out_valid, out_ready = 1'b1, out_misalign;
  logic [63:0] out_rdata;

  logic        addr_mode = 1'b0;
  logic [63:0] tb_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] memf(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0000, a[31:0]};
  endfunction

  assign mem_rdata = addr_mode ? memf(mem_addr) : tb_rdata;

  lsu_req #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_wen(in_wen), .in_ren(in_ren),
    .in_wdt(in_wdt), .in_sext(in_sext),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .mem_resp_ready(mem_resp_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_misalign(out_misalign)
  );

  typedef struct {
    string       nm;
    logic [63:0] addr, wdata;
    logic        wen, ren;
    logic [3:0]  wdt;
    logic        sext;
    logic [63:0] rdata;
    logic        req;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_mask;
    logic        e_wen;
    logic [63:0] e_out;
    logic        e_mis;
  } vec_t;

  function automatic vec_t mk(
    input string nm, input logic [63:0] a, input logic [63:0] wd,
    input logic wen, input logic ren, input logic [3:0] w, input logic sx,
    input logic [63:0] rd, input logic rq, input logic [63:0] ea,
    input logic [63:0] ewd, input logic [7:0] em, input logic ewen,
    input logic [63:0] eo, input logic emis);
    vec_t v;
    v.nm = nm; v.addr = a; v.wdata = wd; v.wen = wen; v.ren = ren;
    v.wdt = w; v.sext = sx; v.rdata = rd; v.req = rq; v.e_addr = ea;
    v.e_wdata = ewd; v.e_mask = em; v.e_wen = ewen; v.e_out = eo; v.e_mis = emis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (in_ready) ok = 1'b1;
    end
    chk({nm, "/back_to_idle"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    chk({v.nm, "/in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_addr = v.addr; in_wdata = v.wdata; in_wen = v.wen;
    in_ren = v.ren; in_wdt = v.wdt; in_sext = v.sext; tb_rdata = v.rdata;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_wen = 1'b0; in_ren = 1'b0;
    if (v.req) begin
      chk({v.nm, "/mem_req_valid"}, {63'd0, mem_req_valid}, 64'd1);
      chk({v.nm, "/mem_addr"},  mem_addr,  v.e_addr);
      chk({v.nm, "/mem_wdata"}, mem_wdata, v.e_wdata);
      chk({v.nm, "/mem_wmask"}, {56'd0, mem_wmask}, {56'd0, v.e_mask});
      chk({v.nm, "/mem_wen"},   {63'd0, mem_wen},   {63'd0, v.e_wen});
      step();
      chk({v.nm, "/mem_resp_ready"}, {63'd0, mem_resp_ready}, 64'd1);
      step();
    end else begin
      chk({v.nm, "/no_mem_req"}, {63'd0, mem_req_valid}, 64'd0);
    end
    chk({v.nm, "/out_valid"},    {63'd0, out_valid}, 64'd1);
    chk({v.nm, "/out_rdata"},    out_rdata, v.e_out);
    chk({v.nm, "/out_misalign"}, {63'd0, out_misalign}, {63'd0, v.e_mis});
    wait_idle(v.nm);
  endtask

  vec_t tv[14];

  initial begin
    int   t0, t1, seen;
    logic [63:0] d0, d1, hold;

    tv[0]  = mk("sb_off3",    64'h8000_0003, 64'hAB, 1, 0, W8, 0, 64'hDEAD_BEEF_CAFE_F00D,
                1, 64'h8000_0000, 64'h0000_0000_AB00_0000, 8'h08, 1, 64'h0, 0);
    tv[1]  = mk("lh_sext",    64'h8000_0006, 64'h0, 0, 1, W16, 1, 64'h8001_0000_0000_0000,
                1, 64'h8000_0000, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_FFFF_8001, 0);
    tv[2]  = mk("lhu",        64'h8000_0006, 64'h0, 0, 1, W16, 0, 64'h8001_0000_0000_0000,
                1, 64'h8000_0000, 64'h0, 8'h00, 0, 64'h0000_0000_0000_8001, 0);
    tv[3]  = mk("lw_misalign",64'h8000_0002, 64'h0, 0, 1, W32, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                0, 64'h0, 64'h0, 8'h00, 0, 64'h0, 1);
    tv[4]  = mk("lb_sext",    64'h8000_0005, 64'h0, 0, 1, W8, 1, 64'h0000_9A00_0000_0000,
                1, 64'h8000_0000, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF9A, 0);
    tv[5]  = mk("lw_sext_pos",64'h8000_0004, 64'h0, 0, 1, W32, 1, 64'h7654_3210_0000_0000,
                1, 64'h8000_0000, 64'h0, 8'h00, 0, 64'h0000_0000_7654_3210, 0);
    tv[6]  = mk("sw_off4",    64'h8000_0004, 64'h1122_3344, 1, 0, W32, 0, 64'h0,
                1, 64'h8000_0000, 64'h1122_3344_0000_0000, 8'hF0, 1, 64'h0, 0);
    tv[7]  = mk("sd",         64'h8000_0008, 64'h0123_4567_89AB_CDEF, 1, 0, W64, 0, 64'h0,
                1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 64'h0, 0);
    tv[8]  = mk("ld_sext_noop",64'h8000_0010, 64'h0, 0, 1, W64, 1, 64'hF000_0000_0000_0001,
                1, 64'h8000_0010, 64'h0, 8'h00, 0, 64'hF000_0000_0000_0001, 0);
    tv[9]  = mk("no_op",      64'h8000_0004, 64'h0, 0, 0, W32, 0, 64'h0,
                0, 64'h0, 64'h0, 8'h00, 0, 64'h0, 0);
    tv[10] = mk("wen_ren_sh", 64'h8000_0002, 64'hBEEF, 1, 1, W16, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                1, 64'h8000_0000, 64'h0000_0000_BEEF_0000, 8'h0C, 1, 64'h0, 0);
    tv[11] = mk("sh_misalign",64'h8000_0001, 64'h1234, 1, 0, W16, 0, 64'h0,
                0, 64'h0, 64'h0, 8'h00, 0, 64'h0, 1);
    tv[12] = mk("bad_wdt_ld", 64'h8000_0000, 64'h0, 0, 1, 4'b0011, 1, 64'h1122_3344_5566_7788,
                1, 64'h8000_0000, 64'h0, 8'h00, 0, 64'h1122_3344_5566_7788, 0);
    tv[13] = mk("bad_wdt_mis",64'h8000_0004, 64'h0, 0, 1, 4'b0000, 0, 64'h0,
                0, 64'h0, 64'h0, 8'h00, 0, 64'h0, 1);

    // Reset values
    #12;
    chk("rst/in_ready",       {63'd0, in_ready},       64'd1);
    chk("rst/mem_req_valid",  {63'd0, mem_req_valid},  64'd0);
    chk("rst/mem_resp_ready", {63'd0, mem_resp_ready}, 64'd0);
    chk("rst/out_valid",      {63'd0, out_valid},      64'd0);
    chk("rst/mem_addr",       mem_addr,  64'd0);
    chk("rst/mem_wmask",      {56'd0, mem_wmask}, 64'd0);
    chk("rst/out_rdata",      out_rdata, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    foreach (tv[i]) run_vec(tv[i]);

    // Backpressure on request, then on result
    in_valid = 1'b1; in_addr = 64'h8000_0004; in_wdata = 64'h55; in_wen = 1'b0;
    in_ren = 1'b1; in_wdt = W32; in_sext = 1'b0; tb_rdata = 64'h7654_3210_0000_0000;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp/req_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("bp/mem_addr",  mem_addr,  64'h8000_0000);
      chk("bp/mem_wdata", mem_wdata, 64'h0000_0055_0000_0000);
      chk("bp/mem_wmask", {56'd0, mem_wmask}, 64'd0);
      chk("bp/in_ready",  {63'd0, in_ready}, 64'd0);
      step();
    end
    mem_req_ready = 1'b1;
    chk("bp/req_valid_last", {63'd0, mem_req_valid}, 64'd1);
    step();
    mem_resp_valid = 1'b1;
    chk("bp/wait", {63'd0, mem_resp_ready}, 64'd1);
    step();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp/out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp/out_rdata", out_rdata, 64'h0000_0000_7654_3210);
      chk("bp/in_ready_resp", {63'd0, in_ready}, 64'd0);
      step();
    end
    out_ready = 1'b1;
    chk("bp/out_valid_last", {63'd0, out_valid}, 64'd1);
    step();
    chk("bp/idle", {63'd0, in_ready}, 64'd1);

    // Reset while waiting for the response
    in_valid = 1'b1; in_addr = 64'h8000_0000; in_ren = 1'b1; in_wen = 1'b0; in_wdt = W64;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    step();
    in_valid = 1'b0; in_ren = 1'b0;
    step();
    chk("rstw/in_wait", {63'd0, mem_resp_ready}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw/in_ready",       {63'd0, in_ready},       64'd1);
    chk("rstw/mem_resp_ready", {63'd0, mem_resp_ready}, 64'd0);
    step();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("rstw/no_out_valid", 64'(seen), 64'd0);

    // Back-to-back doubleword loads, zero-wait memory
    addr_mode = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0; in_wdt = W64; in_sext = 1'b0;
    in_addr = 64'h8000_0000;
    t0 = -1; t1 = -1; d0 = '0; d1 = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) in_addr = 64'h8000_0008;
      if (c == 5) begin in_valid = 1'b0; in_ren = 1'b0; end
      if (out_valid) begin
        if (t0 < 0) begin t0 = c; d0 = out_rdata; end
        else if (t1 < 0 && c > t0) begin t1 = c; d1 = out_rdata; end
      end
    end
    hold = memf(64'h8000_0000);
    chk("b2b/first_cycle", 64'(t0), 64'd3);
    chk("b2b/spacing",     64'(t1 - t0), 64'd4);
    chk("b2b/data0", d0, hold);
    hold = memf(64'h8000_0008);
    chk("b2b/data1", d1, hold);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
